// File: rtl/fir_input_sequencer_if.sv
// Byte-stream, sample and coefficient bundle between the upstream feeder
// side and the FIR input sequencer. The slave modport is the sequencer.
interface fir_input_sequencer_if #(
  parameter int DW = 8
);
  logic          Cfg_start;
  logic          In_valid;
  logic [DW-1:0] In_data;
  logic          In_ready;
  logic [DW-1:0] Data_i;
  logic          Data_vld;
  logic [DW-1:0] B0;
  logic [DW-1:0] B1;
  logic [DW-1:0] B2;
  logic [DW-1:0] B3;
  logic [DW-1:0] B4;
  logic [DW-1:0] B5;
  logic [DW-1:0] B6;
  logic          Busy;
  logic          Frame_done;
  logic [7:0]    Underrun_cnt;

  modport master (
    output Cfg_start, In_valid, In_data,
    input  In_ready, Data_i, Data_vld,
    input  B0, B1, B2, B3, B4, B5, B6,
    input  Busy, Frame_done, Underrun_cnt
  );

  modport slave (
    input  Cfg_start, In_valid, In_data,
    output In_ready, Data_i, Data_vld,
    output B0, B1, B2, B3, B4, B5, B6,
    output Busy, Frame_done, Underrun_cnt
  );
endinterface

// File: rtl/fir_input_sequencer.sv
// Upstream feeder for the FIR filter: loads seven coefficients from a
// valid/ready byte stream, then buffers one frame of samples in a small
// FIFO and issues one sample per clock. Empty-FIFO cycles inside a frame
// are zero-stuffed and counted as underruns (saturating).
module fir_input_sequencer #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_LEN  = 20
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  fir_input_sequencer_if.slave bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FRAME_LEN + 1);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [FW-1:0] FRM_ONE  = FW'(1);
  localparam logic [FW-1:0] FRM_LAST = FW'(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // FSM state
  state_t        state_r;
  state_t        state_nxt_s;

  // Coefficient bank and load index
  logic [DW-1:0] coef_r [7];
  logic [2:0]    coef_idx_r;

  // Sample FIFO
  logic [DW-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;

  // Frame bookkeeping
  logic [FW-1:0] issued_r;
  logic [FW-1:0] pushed_r;
  logic [FW-1:0] pushed_nxt_s;
  logic [7:0]    underrun_r;

  // Registered outputs and their next values
  logic          in_ready_r;
  logic          in_ready_nxt_s;
  logic [DW-1:0] data_r;
  logic [DW-1:0] data_nxt_s;
  logic          vld_r;
  logic          vld_nxt_s;
  logic          frame_done_r;
  logic          frame_done_nxt_s;

  // Qualified events for this cycle
  logic          xfer_s;
  logic          start_s;
  logic          load_wr_s;
  logic          last_coef_s;
  logic          push_s;
  logic          pop_s;
  logic          frame_end_s;
  logic          underrun_s;

  assign xfer_s      = bus.In_valid & in_ready_r;
  assign start_s     = (state_r == ST_IDLE) & bus.Cfg_start;
  assign load_wr_s   = (state_r == ST_LOAD) & xfer_s;
  assign last_coef_s = load_wr_s & (coef_idx_r == 3'd6);
  assign push_s      = (state_r == ST_STREAM) & xfer_s;
  assign pop_s       = (state_r == ST_STREAM) & (count_r != {CW{1'b0}});
  assign frame_end_s = (state_r == ST_STREAM) & (issued_r == FRM_LAST);
  // Zero-stuffing only counts once the frame has started issuing and
  // before its last sample; the initial fill latency is not an underrun.
  assign underrun_s  = (state_r == ST_STREAM) & (count_r == {CW{1'b0}}) &
                       (issued_r != {FW{1'b0}}) & (issued_r < FRM_LAST);

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: start request, seventh coefficient, frame completion
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (last_coef_s) begin
          state_nxt_s = ST_STREAM;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_STREAM: begin
        if (frame_end_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs and occupancy
  always_comb begin
    count_nxt_s      = count_r;
    pushed_nxt_s     = pushed_r;
    in_ready_nxt_s   = 1'b0;
    data_nxt_s       = {DW{1'b0}};
    vld_nxt_s        = 1'b0;
    frame_done_nxt_s = frame_end_s;

    if (start_s) begin
      count_nxt_s  = {CW{1'b0}};
      pushed_nxt_s = {FW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
      if (push_s) begin
        pushed_nxt_s = pushed_r + FRM_ONE;
      end else begin
        pushed_nxt_s = pushed_r;
      end
    end

    // Ready is computed from next-cycle state so that it is a flop output
    // yet still reflects the registered FIFO occupancy and push count.
    case (state_nxt_s)
      ST_LOAD:   in_ready_nxt_s = 1'b1;
      ST_STREAM: in_ready_nxt_s = (count_nxt_s < CNT_FULL) &
                                  (pushed_nxt_s < FRM_LAST);
      default:   in_ready_nxt_s = 1'b0;
    endcase

    if (pop_s) begin
      data_nxt_s = mem_r[rd_ptr_r];
      vld_nxt_s  = 1'b1;
    end else begin
      data_nxt_s = {DW{1'b0}};
      vld_nxt_s  = 1'b0;
    end
  end

  // Registered outputs toward upstream and the FIR
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      in_ready_r   <= 1'b0;
      data_r       <= {DW{1'b0}};
      vld_r        <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      in_ready_r   <= in_ready_nxt_s;
      data_r       <= data_nxt_s;
      vld_r        <= vld_nxt_s;
      frame_done_r <= frame_done_nxt_s;
    end
  end

  // Coefficient bank: each register changes only on its own transfer
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      coef_idx_r <= 3'd0;
      for (int i = 0; i < 7; i++) begin
        coef_r[i] <= {DW{1'b0}};
      end
    end else begin
      if (start_s) begin
        coef_idx_r <= 3'd0;
      end else if (load_wr_s) begin
        coef_idx_r <= coef_idx_r + 3'd1;
      end else begin
        coef_idx_r <= coef_idx_r;
      end
      for (int i = 0; i < 7; i++) begin
        if (load_wr_s && (coef_idx_r == 3'(i))) begin
          coef_r[i] <= bus.In_data;
        end else begin
          coef_r[i] <= coef_r[i];
        end
      end
    end
  end

  // FIFO storage: written on each accepted sample
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (push_s && (wr_ptr_r == AW'(i))) begin
          mem_r[i] <= bus.In_data;
        end else begin
          mem_r[i] <= mem_r[i];
        end
      end
    end
  end

  // FIFO pointers (wrap by width), occupancy and frame counters
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      pushed_r <= {FW{1'b0}};
      issued_r <= {FW{1'b0}};
    end else begin
      count_r  <= count_nxt_s;
      pushed_r <= pushed_nxt_s;
      if (start_s) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        issued_r <= {FW{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
          issued_r <= issued_r + FRM_ONE;
        end else begin
          rd_ptr_r <= rd_ptr_r;
          issued_r <= issued_r;
        end
      end
    end
  end

  // Saturating underrun counter, cleared when a new load starts
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      underrun_r <= 8'd0;
    end else begin
      if (start_s) begin
        underrun_r <= 8'd0;
      end else if (underrun_s && (underrun_r != 8'hFF)) begin
        underrun_r <= underrun_r + 8'd1;
      end else begin
        underrun_r <= underrun_r;
      end
    end
  end

  assign bus.In_ready     = in_ready_r;
  assign bus.Data_i       = data_r;
  assign bus.Data_vld     = vld_r;
  assign bus.Frame_done   = frame_done_r;
  assign bus.Busy         = (state_r != ST_IDLE);
  assign bus.Underrun_cnt = underrun_r;
  assign bus.B0           = coef_r[0];
  assign bus.B1           = coef_r[1];
  assign bus.B2           = coef_r[2];
  assign bus.B3           = coef_r[3];
  assign bus.B4           = coef_r[4];
  assign bus.B5           = coef_r[5];
  assign bus.B6           = coef_r[6];

endmodule

// File: doc/fir_input_sequencer.md
# fir_input_sequencer

Upstream feeder for the FIRROOT filter. Loads the seven 8-bit coefficients B0..B6 from a single valid/ready byte stream, then accepts a frame of samples on the same stream, buffers them in a small FIFO and presents one sample per clock on Data_i. The FIR has no valid input, so gaps are zero-stuffed and counted as underruns.

## Interface
- DW, 8, width of coefficients and samples
- FIFO_DEPTH, 4, sample buffer depth (power of two, ≥2)
- FRAME_LEN, 20, samples issued per frame before returning to idle
---
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  reset; asynchronous, active-low
- Cfg_start  in  1  single-cycle start request; honoured only in IDLE
- In_valid  in  1  upstream byte valid
- In_data  in  DW  coefficient byte (LOAD) or sample (STREAM)
- In_ready  out  1  block accepts In_data this cycle
- Data_i  out  DW  sample to FIR, registered
- Data_vld  out  1  Data_i carries a real sample this cycle
- B0..B6  out  DW each  coefficient registers to FIR
- Busy  out  1  state ≠ IDLE
- Frame_done  out  1  one-cycle pulse after last sample of frame issued
- Underrun_cnt  out  8  saturating count of zero-stuffed cycles

## Operation
- FSM states: IDLE, LOAD, STREAM. Transfer = In_valid & In_ready at a rising edge.
- IDLE: In_ready=0, Data_i=0, Data_vld=0. Cfg_start=1 → LOAD; same edge clears coef index, Underrun_cnt, FIFO, issued and pushed counters.
- LOAD: In_ready=1. Each transfer writes In_data to B[idx], idx 0→6 in order (first byte → B0). Transfer with idx=6 → STREAM. B registers change only on their own transfer.
- STREAM: In_ready = (fifo_count < FIFO_DEPTH) & (pushed < FRAME_LEN), both from registered state; no push when full even if a pop occurs the same cycle. Transfers beyond FRAME_LEN are impossible (In_ready low).
- Pop every cycle the FIFO is non-empty: Data_i ← head, Data_vld ← 1, issued++.
- FIFO empty with issued ≥ 1 and issued < FRAME_LEN: Data_i ← 0, Data_vld ← 0, Underrun_cnt++ (saturate at 255). Empty before first issue: zero output, not counted.
- Pop making issued = FRAME_LEN: next cycle Frame_done=1, state → IDLE, Data_i ← 0, Data_vld ← 0.
- B0..B6 hold their values in IDLE and STREAM until the next LOAD overwrites them individually.
- Cfg_start outside IDLE ignored.
- FIFO pointers wrap modulo FIFO_DEPTH; count kept separately (0..FIFO_DEPTH).

## Timing
- Reset (async assert, sync-to-Clk release effect): state IDLE, B0..B6=0, Data_i=0, Data_vld=0, In_ready=0, Busy=0, Frame_done=0, Underrun_cnt=0, FIFO empty. Reset mid-LOAD or mid-STREAM discards everything, including already loaded coefficients.
- Cfg_start at edge k → In_ready=1 after edge k; first coefficient can transfer at edge k+1.
- Coefficient transferred at edge k visible on B[idx] after edge k.
- Sample transferred into empty FIFO at edge k → on Data_i with Data_vld=1 after edge k+1 (1-cycle latency).
- Sustained In_valid=1 in STREAM: one sample per cycle on Data_i, no underruns; FIFO never exceeds 1 entry.
- Frame_done high exactly one cycle, the cycle after the last Data_vld=1; Busy falls same cycle.
- Minimum load-to-last-sample: 1 + 7 + 1 + FRAME_LEN cycles.

## Test plan
- Reset mid-STREAM (Rst_n low 3 ns, unaligned) → all outputs zero immediately, B0..B6=0, Busy=0; fresh Cfg_start works.
- Cfg_start, then bytes 0x01..0x07 with In_valid held → B0=0x01 … B6=0x07, STREAM entered after 7th transfer, In_valid gaps during LOAD stall index without skipping.
- Continuous samples 0x10..0x23 (20) → Data_i shows 0x10..0x23 on 20 consecutive cycles, Data_vld=1 throughout, Frame_done one cycle after, Underrun_cnt=0, In_ready=0 after 20th transfer.
- Samples with In_valid low for 3 cycles after sample 5 → Data_i=0, Data_vld=0 for exactly 3 cycles, Underrun_cnt=3, frame still ends after 20 real samples.
- Burst with downstream-independent fill: In_valid low for first 4 STREAM cycles, then stream → those 4 cycles not counted (Underrun_cnt=0).
- Cfg_start pulsed during STREAM → ignored, coefficients unchanged; 300 underrun cycles forced across frames → Underrun_cnt saturates at 255.
